// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic LEGv8-subset operation requests into 32-bit machine words.
// Each encoded word is written to the next instruction-memory address, starting at 0.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   clear               synchronous restart (count, state and error status)
//   in_valid/in_ready   request handshake; in_ready does not depend on in_valid
//   in_op, in_rd, in_rn, in_rm, in_imm, in_cond   request fields
//   imem_we/addr/wdata  registered instruction-memory write port (1-cycle latency)
//   count, full         words written since reset/clear; full when count == DEPTH
//   err, err_op         sticky rejection flag; opcode of the most recent rejected request
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  input  logic [4:0]        in_cond,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [3:0]        err_op
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

  typedef enum logic [0:0] {StLoad, StFull} state_e;

  state_e            r_state;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [3:0]        r_err_op;

  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_word;
  logic        w_fits9;   // in_imm representable as signed 9-bit
  logic        w_fits19;  // in_imm representable as signed 19-bit

  // A signed value fits in N bits when every bit above N-1 equals the sign bit.
  assign w_fits9  = (in_imm[25:8] == '0) || (in_imm[25:8] == '1);
  assign w_fits19 = (in_imm[25:18] == '0) || (in_imm[25:18] == '1);

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (in_op)
      4'd0: begin  // ADDI
        w_word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
        w_legal = (in_imm[25:12] == '0);
      end
      4'd1: w_word = {11'b10101011000, in_rm, 6'b000000, in_rn, in_rd};  // ADDS
      4'd2: w_word = {11'b11101011000, in_rm, 6'b000000, in_rn, in_rd};  // SUBS
      4'd3: w_word = {11'b10011011000, in_rm, 6'b011111, in_rn, in_rd};  // MUL
      4'd4: begin  // LSL
        w_word  = {11'b11010011011, 5'b00000, in_imm[5:0], in_rn, in_rd};
        w_legal = (in_imm[25:6] == '0);
      end
      4'd5: begin  // LSR
        w_word  = {11'b11010011010, 5'b00000, in_imm[5:0], in_rn, in_rd};
        w_legal = (in_imm[25:6] == '0);
      end
      4'd6: begin  // LDUR
        w_word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = w_fits9;
      end
      4'd7: begin  // STUR
        w_word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = w_fits9;
      end
      4'd8: w_word = {6'b000101, in_imm};  // B: every offset is encodable
      4'd9: begin  // B.cond
        w_word  = {8'b01010100, in_imm[18:0], in_cond};
        w_legal = w_fits19 && (in_cond <= 5'd13);
      end
      4'd10: begin  // CBZ
        w_word  = {8'b10110100, in_imm[18:0], in_rd};
        w_legal = w_fits19;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready = (r_state == StLoad) && !clear && !reset;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StLoad;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_err_op <= '0;
    end else if (clear) begin
      // Address/data hold; only the strobe drops since nothing is accepted this edge.
      r_state  <= StLoad;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_err_op <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_addr  <= r_count[ADDR_W-1:0];
          r_wdata <= w_word;
          r_count <= r_count + CountOne;
          if (r_count == LastIdx) begin
            r_state <= StFull;
          end
        end else begin
          r_err    <= 1'b1;
          r_err_op <= in_op;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = (r_state == StFull);
  assign err        = r_err;
  assign err_op     = r_err_op;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0, in_cond = '0;
  logic [25:0]   in_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, err;
  logic [3:0]    err_op;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .in_cond    (in_cond),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .err_op     (err_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     m_count  = 0;
  bit     m_err    = 0;
  int     m_err_op = 0;
  bit     m_we     = 0;
  int     m_addr   = 0;
  longint m_wdata  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sval(input int imm);
    return (imm >= 33554432) ? imm - 67108864 : imm;
  endfunction

  function automatic bit ref_legal(input int op, input int imm, input int cond);
    int s;
    s = sval(imm);
    case (op)
      0:       return imm <= 4095;
      1, 2, 3: return 1'b1;
      4, 5:    return imm <= 63;
      6, 7:    return (s >= -256) && (s <= 255);
      8:       return 1'b1;
      9:       return (s >= -262144) && (s <= 262143) && (cond <= 13);
      10:      return (s >= -262144) && (s <= 262143);
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint ref_enc(input int op, input int rd, input int rn, input int rm,
                                     input int imm, input int cond);
    longint base;
    int s, i9, i19;
    s    = sval(imm);
    i9   = ((s % 512) + 512) % 512;
    i19  = ((s % 524288) + 524288) % 524288;
    base = longint'(rn) * 32 + rd;
    case (op)
      0:  return longint'(580) * 4194304 + longint'(imm % 4096) * 1024 + base;
      1:  return longint'(1368) * 2097152 + longint'(rm) * 65536 + base;
      2:  return longint'(1880) * 2097152 + longint'(rm) * 65536 + base;
      3:  return longint'(1240) * 2097152 + longint'(rm) * 65536 + 31 * 1024 + base;
      4:  return longint'(1691) * 2097152 + longint'(imm % 64) * 1024 + base;
      5:  return longint'(1690) * 2097152 + longint'(imm % 64) * 1024 + base;
      6:  return longint'(1986) * 2097152 + longint'(i9) * 4096 + base;
      7:  return longint'(1984) * 2097152 + longint'(i9) * 4096 + base;
      8:  return longint'(5) * 67108864 + imm;
      9:  return longint'(84) * 16777216 + longint'(i19) * 32 + cond;
      10: return longint'(180) * 16777216 + longint'(i19) * 32 + rd;
      default: return 0;
    endcase
  endfunction

  task automatic req(input int op, input int rd, input int rn, input int rm, input int imm,
                     input int cond);
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rd    = 5'(rd);
    in_rn    = 5'(rn);
    in_rm    = 5'(rm);
    in_imm   = 26'(imm);
    in_cond  = 5'(cond);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic rand_req();
    int imm_pick[14] = '{4095, 4096, 63, 64, 255, 256, 67108608, 67108607, 262143, 262144,
                         66846720, 66846719, 0, 67108863};
    int op, imm;
    op = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
    case ($urandom_range(0, 2))
      0:       imm = $urandom_range(0, 70);
      1:       imm = int'($urandom_range(0, 67108863));
      default: imm = imm_pick[$urandom_range(0, 13)];
    endcase
    req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm,
        $urandom_range(0, 15));
  endtask

  // One clock: predict from the current inputs, advance, compare all outputs.
  task automatic cycle();
    bit rdy, acc, lg;
    longint enc;
    #1;
    rdy = !reset && !clear && (m_count < DEPTH);
    check("in_ready", 32'(in_ready), 32'(rdy));
    acc = rdy && in_valid;
    lg  = ref_legal(int'(in_op), int'(in_imm), int'(in_cond));
    enc = ref_enc(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), int'(in_imm),
                  int'(in_cond));
    if (reset) begin
      m_count = 0; m_err = 0; m_err_op = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    end else if (clear) begin
      m_count = 0; m_err = 0; m_err_op = 0; m_we = 0;
    end else begin
      m_we = 0;
      if (acc) begin
        if (lg) begin
          m_we = 1; m_addr = m_count; m_wdata = enc; m_count++;
        end else begin
          m_err = 1; m_err_op = int'(in_op);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("imem_we", 32'(imem_we), 32'(m_we));
    check("imem_addr", 32'(imem_addr), 32'(m_addr));
    check("imem_wdata", imem_wdata, m_wdata[31:0]);
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err", 32'(err), 32'(m_err));
    check("err_op", 32'(err_op), 32'(m_err_op));
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;

    // ADDI rd=1 rn=2 imm=5
    req(0, 1, 2, 0, 5, 0);
    cycle();
    check("addi_word", imem_wdata, 32'h91001441);
    check("addi_count", 32'(count), 32'd1);
    idle();
    cycle();

    clear = 1'b1;
    cycle();
    clear = 1'b0;

    // Back-to-back, no bubbles
    req(3, 5, 6, 7, 0, 0);
    cycle();
    check("mul_word", imem_wdata, 32'h9B077CC5);
    req(7, 3, 4, 0, -8, 0);
    cycle();
    check("stur_word", imem_wdata, 32'hF81F8083);
    check("stur_addr", 32'(imem_addr), 32'd1);
    req(8, 0, 0, 0, -1, 0);
    cycle();
    check("b_word", imem_wdata, 32'h17FFFFFF);
    req(9, 0, 0, 0, 2, 1);
    cycle();
    check("bcond_word", imem_wdata, 32'h54000041);
    check("bcond_addr", 32'(imem_addr), 32'd3);
    check("b2b_count", 32'(count), 32'd4);

    // Illegal requests
    req(0, 1, 1, 0, 4096, 0);
    cycle();
    check("illegal_we", 32'(imem_we), 32'd0);
    check("illegal_err", 32'(err), 32'd1);
    req(12, 0, 0, 0, 0, 0);
    cycle();
    check("illegal_op", 32'(err_op), 32'd12);
    check("illegal_count", 32'(count), 32'd4);

    // Mid-stream reset drops the pending write on the following edge
    req(1, 2, 3, 4, 0, 0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Randomized traffic with occasional clear/reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rand_req(); else idle();
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear = 1'b0;
    reset = 1'b0;

    // Fill to DEPTH
    clear = 1'b1;
    idle();
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 1000 && m_count < DEPTH; i++) begin
      rand_req();
      cycle();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(DEPTH));
    req(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("full_no_write", 32'(imem_we), 32'd0);

    // clear while FULL, with a request present in the same cycle
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_full", 32'(full), 32'd0);
    req(0, 4, 5, 0, 100, 0);
    cycle();
    check("clr_addr0", 32'(imem_addr), 32'd0);
    check("clr_we", 32'(imem_we), 32'd1);

    // reset in the same cycle as a request
    req(0, 7, 7, 0, 7, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    cycle();
    check("rst_req_we", 32'(imem_we), 32'd0);
    check("rst_req_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
